// File: rtl/tage_update_ctrl.sv
// -----------------------------------------------------------------------------
// tage_update_ctrl
//
// Sequences TAGE predictor table writes for resolved branches. Resolves are
// queued in a small FIFO; each head entry is processed by a three-state FSM:
//   IDLE   -> UPDATE when the queue holds an entry.
//   UPDATE -> one cycle; refreshes the provider table entry (if any).
//   ALLOC  -> on a misprediction, tries to allocate a new entry in the tables
//             above the provider, one table per cycle in ascending order,
//             stopping at the first table that reports success.
//
// Ports
//   clk, rst            sole clock, synchronous active-high reset
//   IN_resValid         resolve offered; accepted when OUT_resReady is high
//   OUT_resReady        queue can take a resolve this cycle
//   IN_resAddr/Tag      per-table index (6b) / tag (8b), table k at slice k
//   IN_resProvValid     a tagged table provided the prediction
//   IN_resProvIdx       provider table number
//   IN_resPredTaken     final prediction;  IN_resTaken  actual outcome
//   OUT_write*          per-table write strobes and data bits (bit k = table k)
//   OUT_writeAddr/Tag   head entry index/tag, driven whenever not IDLE
//   OUT_anyAlloc        high in the UPDATE cycle that decides to allocate
//   IN_writeAlloc       per-table allocation success, same-cycle feedback
//   OUT_busy            FSM not IDLE or queue non-empty
//
// Build option
//   TAGE_ALLOC_RAND_EN  adds a 16-bit LFSR that randomly skips the first
//                       allocation candidate when at least two exist.
// -----------------------------------------------------------------------------
module tage_update_ctrl #(
  parameter int NUM_TABLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    IN_resValid,
  output logic                    OUT_resReady,
  input  logic [NUM_TABLES*6-1:0] IN_resAddr,
  input  logic [NUM_TABLES*8-1:0] IN_resTag,
  input  logic                    IN_resProvValid,
  input  logic [2:0]              IN_resProvIdx,
  input  logic                    IN_resPredTaken,
  input  logic                    IN_resTaken,
  output logic [NUM_TABLES-1:0]   OUT_writeValid,
  output logic [NUM_TABLES-1:0]   OUT_writeUpdate,
  output logic [NUM_TABLES-1:0]   OUT_writeNew,
  output logic [NUM_TABLES-1:0]   OUT_writeTaken,
  output logic [NUM_TABLES-1:0]   OUT_writeUseful,
  output logic [NUM_TABLES*6-1:0] OUT_writeAddr,
  output logic [NUM_TABLES*8-1:0] OUT_writeTag,
  output logic                    OUT_anyAlloc,
  input  logic [NUM_TABLES-1:0]   IN_writeAlloc,
  output logic                    OUT_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [NUM_TABLES-1:0] ONE = {{(NUM_TABLES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, UPDATE, ALLOC} state_e;

  typedef struct packed {
    logic [NUM_TABLES*6-1:0] addr;
    logic [NUM_TABLES*8-1:0] tag;
    logic                    prov_valid;
    logic [2:0]              prov_idx;
    logic                    pred_taken;
    logic                    taken;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Resolve queue: pointers carry one extra wrap bit to tell full from empty.
  // ---------------------------------------------------------------------------
  entry_t         fifo_q [FIFO_DEPTH];
  entry_t         in_entry, head;
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic           empty, full, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign OUT_resReady = !full && !rst;
  assign push         = IN_resValid && OUT_resReady;

  assign in_entry = '{addr: IN_resAddr, tag: IN_resTag, prov_valid: IN_resProvValid,
                      prov_idx: IN_resProvIdx, pred_taken: IN_resPredTaken,
                      taken: IN_resTaken};
  assign head     = fifo_q[rd_ptr_q[PTR_W-1:0]];

  assign wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};

  // NOTE: the storage array has no reset; an entry is only read after the
  // pointers say it was written, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[PTR_W-1:0]] <= in_entry;
  end

  // ---------------------------------------------------------------------------
  // Candidate selection for allocation.
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [3:0]            cur_q, cur_d;       // table being attempted in ALLOC
  logic                  prov_hit, mispred, has_cand;
  logic [3:0]            first_cand, start_cand;
  logic [NUM_TABLES-1:0] prov_oh, cur_oh;

  // An out-of-range provider index is treated as "no provider".
  assign prov_hit   = head.prov_valid && ({1'b0, head.prov_idx} < 4'(NUM_TABLES));
  assign mispred    = (head.pred_taken != head.taken);
  assign first_cand = prov_hit ? ({1'b0, head.prov_idx} + 4'd1) : 4'd0;
  assign has_cand   = (first_cand < 4'(NUM_TABLES));
  assign prov_oh    = ONE << head.prov_idx;
  assign cur_oh     = ONE << cur_q;

`ifdef TAGE_ALLOC_RAND_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        two_plus;

  assign two_plus   = ((first_cand + 4'd1) < 4'(NUM_TABLES));
  assign start_cand = (lfsr_q[0] && two_plus) ? (first_cand + 4'd1) : first_cand;
  // Galois LFSR, advanced once per entry into ALLOC.
  assign lfsr_d     = (state_q == UPDATE && state_d == ALLOC)
                      ? ((lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000))
                      : lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign start_cand = first_cand;
`endif

  // ---------------------------------------------------------------------------
  // FSM next-state and outputs.
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so no path can leave
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d         = state_q;
    cur_d           = cur_q;
    pop             = 1'b0;
    OUT_writeValid  = '0;
    OUT_writeUpdate = '0;
    OUT_writeNew    = '0;
    OUT_writeTaken  = '0;
    OUT_writeUseful = '0;
    OUT_writeAddr   = '0;
    OUT_writeTag    = '0;
    OUT_anyAlloc    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = UPDATE;
      end

      UPDATE: begin
        OUT_writeAddr = head.addr;
        OUT_writeTag  = head.tag;
        if (prov_hit) begin
          OUT_writeValid  = prov_oh;
          OUT_writeUpdate = prov_oh;
          OUT_writeTaken  = head.taken ? prov_oh : '0;
          OUT_writeUseful = mispred ? '0 : prov_oh;
        end
        if (mispred && has_cand) begin
          state_d      = ALLOC;
          cur_d        = start_cand;
          OUT_anyAlloc = 1'b1;
        end else begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end

      ALLOC: begin
        OUT_writeAddr  = head.addr;
        OUT_writeTag   = head.tag;
        OUT_writeValid = cur_oh;
        OUT_writeNew   = cur_oh;
        OUT_writeTaken = head.taken ? cur_oh : '0;
        if (|(IN_writeAlloc & cur_oh) || cur_q == 4'(NUM_TABLES - 1)) begin
          pop     = 1'b1;
          state_d = IDLE;
        end else begin
          cur_d = cur_q + 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign OUT_busy = (state_q != IDLE) || !empty;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: tb/tb_tage_update_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tage_update_ctrl
//
// Directed testbench for tage_update_ctrl (NUM_TABLES=4, FIFO_DEPTH=4).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_tage_update_ctrl;

  localparam int NT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          IN_resValid;
  logic          OUT_resReady;
  logic [NT*6-1:0] IN_resAddr;
  logic [NT*8-1:0] IN_resTag;
  logic          IN_resProvValid;
  logic [2:0]    IN_resProvIdx;
  logic          IN_resPredTaken;
  logic          IN_resTaken;
  logic [NT-1:0] OUT_writeValid, OUT_writeUpdate, OUT_writeNew;
  logic [NT-1:0] OUT_writeTaken, OUT_writeUseful;
  logic [NT*6-1:0] OUT_writeAddr;
  logic [NT*8-1:0] OUT_writeTag;
  logic          OUT_anyAlloc;
  logic [NT-1:0] IN_writeAlloc;
  logic          OUT_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tage_update_ctrl #(.NUM_TABLES(NT), .FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .IN_resValid     (IN_resValid),
    .OUT_resReady    (OUT_resReady),
    .IN_resAddr      (IN_resAddr),
    .IN_resTag       (IN_resTag),
    .IN_resProvValid (IN_resProvValid),
    .IN_resProvIdx   (IN_resProvIdx),
    .IN_resPredTaken (IN_resPredTaken),
    .IN_resTaken     (IN_resTaken),
    .OUT_writeValid  (OUT_writeValid),
    .OUT_writeUpdate (OUT_writeUpdate),
    .OUT_writeNew    (OUT_writeNew),
    .OUT_writeTaken  (OUT_writeTaken),
    .OUT_writeUseful (OUT_writeUseful),
    .OUT_writeAddr   (OUT_writeAddr),
    .OUT_writeTag    (OUT_writeTag),
    .OUT_anyAlloc    (OUT_anyAlloc),
    .IN_writeAlloc   (IN_writeAlloc),
    .OUT_busy        (OUT_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input logic [NT-1:0] wv, input logic [NT-1:0] upd,
                             input logic [NT-1:0] nw, input logic [NT-1:0] tk,
                             input logic [NT-1:0] use_b);
    check({tag, ".valid"},  OUT_writeValid,  wv);
    check({tag, ".update"}, OUT_writeUpdate, upd);
    check({tag, ".new"},    OUT_writeNew,    nw);
    check({tag, ".taken"},  OUT_writeTaken,  tk);
    check({tag, ".useful"}, OUT_writeUseful, use_b);
  endtask

  task automatic offer(input logic pv, input logic [2:0] pi, input logic pt, input logic tk,
                       input logic [NT*6-1:0] addr, input logic [NT*8-1:0] tag);
    IN_resProvValid = pv;
    IN_resProvIdx   = pi;
    IN_resPredTaken = pt;
    IN_resTaken     = tk;
    IN_resAddr      = addr;
    IN_resTag       = tag;
    IN_resValid     = 1'b1;
  endtask

  task automatic push(input logic pv, input logic [2:0] pi, input logic pt, input logic tk,
                      input logic [NT*6-1:0] addr, input logic [NT*8-1:0] tag);
    offer(pv, pi, pt, tk, addr, tag);
    step();
    IN_resValid = 1'b0;
  endtask

  // Steps until the write address is (in)active, bounded; a timeout fails the check.
  task automatic wait_active(input logic want, input string tag);
    int n = 0;
    while (((OUT_writeAddr != '0) != want) && n < 50) begin
      step();
      n++;
    end
    check(tag, {63'd0, (OUT_writeAddr != '0) == want}, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NT*6-1:0] bp_addr [4];
    bp_addr = '{24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C, 24'h0D0D0D};

    rst = 1'b1;
    IN_resValid = 1'b0;
    IN_resAddr = '0;
    IN_resTag = '0;
    IN_resProvValid = 1'b0;
    IN_resProvIdx = '0;
    IN_resPredTaken = 1'b0;
    IN_resTaken = 1'b0;
    IN_writeAlloc = '0;

    // Reset state
    step();
    step();
    check("rst_ready", OUT_resReady, 0);
    check("rst_busy", OUT_busy, 0);
    check("rst_wv", OUT_writeValid, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", OUT_resReady, 1);

    // Provider hit, correct prediction: single update cycle on table 2
    push(1'b1, 3'd2, 1'b1, 1'b1, 24'h123456, 32'hA1B2C3D4);
    check("hit_idle_busy", OUT_busy, 1);
    check("hit_idle_wv", OUT_writeValid, 0);
    step();
    check_write("hit_upd", 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
    check("hit_addr", OUT_writeAddr, 24'h123456);
    check("hit_tag", OUT_writeTag, 32'hA1B2C3D4);
    step();
    check("hit_done_busy", OUT_busy, 0);
    check("hit_done_wv", OUT_writeValid, 0);
    check("hit_done_addr", OUT_writeAddr, 0);

    // Mispredict with provider 0, table 1 accepts allocation
    IN_writeAlloc = 4'b0010;
    push(1'b1, 3'd0, 1'b1, 1'b0, 24'h222222, 32'h22222222);
    step();
    check_write("mp_upd", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    step();
    check_write("mp_alloc", 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    check("mp_alloc_any", OUT_anyAlloc, 0);
    step();
    check("mp_done_busy", OUT_busy, 0);
    check("mp_done_wv", OUT_writeValid, 0);
    IN_writeAlloc = '0;

    // No provider, mispredict, every allocation attempt fails
    push(1'b0, 3'd0, 1'b0, 1'b1, 24'h333333, 32'h33333333);
    step();
    check_write("fa_upd", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("fa_upd_busy", OUT_busy, 1);
    for (int i = 0; i < NT; i++) begin
      logic [NT-1:0] exp_oh;
      exp_oh = 4'b0001 << i;
      step();
      check_write($sformatf("fa_alloc%0d", i), exp_oh, 4'b0000, exp_oh, exp_oh, 4'b0000);
    end
    step();
    check("fa_done_busy", OUT_busy, 0);
    check("fa_done_wv", OUT_writeValid, 0);

    // Top-table provider mispredict: update only, no candidates above
    push(1'b1, 3'd3, 1'b0, 1'b1, 24'h444444, 32'h44444444);
    step();
    check_write("top_upd", 4'b1000, 4'b1000, 4'b0000, 4'b1000, 4'b0000);
    step();
    check("top_done_busy", OUT_busy, 0);
    check("top_done_wv", OUT_writeValid, 0);

    // Out-of-range provider index behaves as no provider
    IN_writeAlloc = 4'b0001;
    push(1'b1, 3'd5, 1'b1, 1'b0, 24'h555555, 32'h55555555);
    step();
    check("oor_upd_wv", OUT_writeValid, 0);
    step();
    check_write("oor_alloc", 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    step();
    check("oor_done_busy", OUT_busy, 0);
    IN_writeAlloc = '0;

    // Backpressure: four long resolves fill the queue, a fifth is refused
    for (int k = 0; k < 4; k++) begin
      offer(1'b0, 3'd0, 1'b1, 1'b0, bp_addr[k], 32'h0);
      check($sformatf("bp_ready%0d", k), OUT_resReady, 1);
      step();
    end
    offer(1'b0, 3'd0, 1'b1, 1'b0, 24'h0E0E0E, 32'h0);
    check("bp_full_ready", OUT_resReady, 0);
    check("bp_busy", OUT_busy, 1);
    check("bp_order0", OUT_writeAddr, bp_addr[0]);
    #1;
    IN_resValid = 1'b0;
    for (int k = 1; k < 4; k++) begin
      wait_active(1'b0, "bp_gap");
      check("bp_ready_again", OUT_resReady, 1);
      wait_active(1'b1, "bp_start");
      check($sformatf("bp_order%0d", k), OUT_writeAddr, bp_addr[k]);
    end
    begin
      int n = 0;
      while (OUT_busy && n < 50) begin
        step();
        n++;
      end
    end
    check("bp_drained", OUT_busy, 0);

    // Reset during the second allocation attempt
    push(1'b0, 3'd0, 1'b1, 1'b0, 24'h666666, 32'h66666666);
    step();
    check("ra_upd_wv", OUT_writeValid, 0);
    step();
    check("ra_alloc0", OUT_writeValid, 4'b0001);
    step();
    check("ra_alloc1", OUT_writeValid, 4'b0010);
    rst = 1'b1;
    #1;
    check("ra_rst_ready", OUT_resReady, 0);
    step();
    check("ra_rst_wv", OUT_writeValid, 0);
    check("ra_rst_busy", OUT_busy, 0);
    check("ra_rst_ready2", OUT_resReady, 0);
    rst = 1'b0;
    #1;
    check("ra_ready_after", OUT_resReady, 1);
    step();
    check("ra_after_wv", OUT_writeValid, 0);
    check("ra_after_busy", OUT_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
